vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage for the PPU, the next generation of our fixed 640x480 driver. It sources the fetch coordinates the PPU uses to look up pixel colour, and compensates a configurable PPU read latency so sync, blank and colour stay aligned at the DAC. It also provides line, frame and vblank strobes for buffer swapping. It drives the VGA connector (RGB DAC, HSYNC, VSYNC, BLANK_N, SYNC_N, CLK) directly.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_PULSE / H_BACK, 16 / 96 / 48, horizontal porch and pulse widths in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FRONT / V_PULSE / V_BACK, 10 / 2 / 33, vertical porch and pulse widths in lines
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active-low)
- LAT, 1, PPU read latency in clocks from fetch coordinate to colour input; legal range 0..7
- CW, 8, bits per colour channel
- XW / YW, 10 / 10, coordinate and counter widths; must hold H_TOTAL-1 and V_TOTAL-1
- clock  in  1  pixel clock (25.175 MHz for the default mode)
- rst  in  1  synchronous active-high reset
- r_in / g_in / b_in  in  CW each  colour for the coordinate issued LAT cycles earlier
- fetch_x  out  XW  horizontal counter when fetch_valid, else 0
- fetch_y  out  YW  vertical counter when fetch_valid, else 0
- fetch_valid  out  1  current counters are inside the active area
- line_start  out  1  one-clock pulse at h=0 on every line
- frame_start  out  1  one-clock pulse at h=0, v=0
- vblank_start  out  1  one-clock pulse at h=0, v=V_ACTIVE
- vblank  out  1  high while v >= V_ACTIVE
- hsync / vsync  out  1  sync outputs at the configured polarity
- red / green / blue  out  CW each  DAC colour, forced to 0 outside the active area
- blank_n  out  1  high when displayed pixel is active
- sync_n  out  1  constant 0
- vga_clk  out  1  equals clock

## Operation
- H_TOTAL = sum of the four H parameters. V_TOTAL = sum of the four V parameters. Each parameter gives an exact count; there is no minus-one encoding.
- h counter runs 0..H_TOTAL-1 and wraps to 0. v counter increments when h wraps, and runs 0..V_TOTAL-1 and wraps to 0.
- Fetch-side regions are combinational from the counters:
  - active: h<H_ACTIVE and v<V_ACTIVE
  - hsync asserted: H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_PULSE
  - vsync asserted: V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_PULSE
  - vsync changes only at h=0.
- fetch_x, fetch_y, fetch_valid, line_start, frame_start, vblank_start and vblank are combinational from the counters. They have no delay.
- Display path:
  - The raw active, hsync and vsync flags pass through a LAT-stage delay line.
  - The delayed flags, together with r_in/g_in/b_in gated by delayed active, are then registered once.
  - Total display latency from fetch coordinate to pins is LAT+1 clocks.
- Sync pins are driven to HS_POL/VS_POL when asserted and to the inverse when deasserted.

## Timing
- Reset (rst high at a clock edge):
  - h and v counters, and all delay-line stages, go to 0 and inactive.
  - red/green/blue = 0, blank_n = 0, hsync = ~HS_POL, vsync = ~VS_POL.
  - The delay line is flushed with inactive flags.
- First clock after reset release: h=0, v=0, so fetch_valid=1, fetch_x=0, fetch_y=0, line_start=1, frame_start=1.
- Pixel (x,y) is issued at fetch cycle t. Its colour is sampled from the inputs at t+LAT and appears on red/green/blue at t+LAT+1.
- LAT=0: colour is sampled in the same cycle as the coordinate.
- Reset mid-frame restarts at h=0, v=0 on the next clock. No partial sync pulse survives reset, because the delay line is cleared.
- Simultaneous events are defined as follows:
  - The h wrap and v wrap at the end of the frame occur in the same clock.
  - frame_start and line_start are both high at h=0, v=0.
  - vblank_start and line_start are both high at h=0, v=V_ACTIVE.
- Sync pins are glitch-free because they are driven from registers only.

## Structure
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants
  - a second mode set: 800x600@60, 40 MHz
  - the derived H_TOTAL/V_TOTAL functions
  - the polarity encoding constants
- Sub-module vga_delay_line:
  - parametrised WIDTH x DEPTH shift register with synchronous active-high reset to 0
  - DEPTH=0 is a pass-through
  - carries {active, hs, vs}

## Test plan
- Reset: hold rst 5 clocks with random r/g/b inputs → red/green/blue=0, blank_n=0, hsync=vsync=1 (defaults). The first clock after release has frame_start=1, fetch_x=0, fetch_y=0.
- Horizontal timing, defaults: hsync pin low for exactly 96 clocks per line, period 800. Its falling edge comes 656+LAT+1 clocks after line_start. line_start pulses every 800 clocks.
- Vertical timing: vsync low for exactly 2 lines (1600 clocks), frame period 420000 clocks. vblank_start occurs at v=480, and vblank is high for 45 lines.
- Latency alignment with LAT=3 and a model returning r_in = fetch_x[7:0] delayed 3 clocks → red on the first active pixel of each line is 0, the last is 0x7F (639 mod 256 = 127). Output is 0 everywhere blank_n=0.
- Polarity and mode: the 800x600 set with HS_POL=VS_POL=1 → hsync high for 128 clocks in a 1056-clock line; vsync high for 4 lines in a 628-line frame.
- Mid-frame reset: assert rst at v=200, h=300 → the next clock has h=0, v=0 and frame_start=1. Display outputs stay inactive for LAT+1 clocks after release, with no stray sync pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, polarity encoding and derived-total helpers.
// Mode sets: 640x480@60 (25.175 MHz) default and 800x600@60 (40 MHz).
package vga_pkg;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_H_PULSE  = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_V_PULSE  = 2;
    localparam int VGA640_V_BACK   = 33;
    localparam logic VGA640_HS_POL = POL_ACTIVE_LOW;
    localparam logic VGA640_VS_POL = POL_ACTIVE_LOW;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FRONT  = 40;
    localparam int SVGA800_H_PULSE  = 128;
    localparam int SVGA800_H_BACK   = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FRONT  = 1;
    localparam int SVGA800_V_PULSE  = 4;
    localparam int SVGA800_V_BACK   = 23;
    localparam logic SVGA800_HS_POL = POL_ACTIVE_HIGH;
    localparam logic SVGA800_VS_POL = POL_ACTIVE_HIGH;

    // Flags carried through the latency-compensation delay line.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_flags_t;

    function automatic int h_total(input int active, input int front, input int pulse, input int back);
        return active + front + pulse + back;
    endfunction

    function automatic int v_total(input int active, input int front, input int pulse, input int back);
        return active + front + pulse + back;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with synchronous active-high clear.
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_data   = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster counter, fetch-coordinate source and registered DAC/sync stage.
// Display outputs trail the fetch coordinate by LAT+1 clocks to absorb PPU read latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FRONT  = VGA640_H_FRONT,
    parameter int   H_PULSE  = VGA640_H_PULSE,
    parameter int   H_BACK   = VGA640_H_BACK,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FRONT  = VGA640_V_FRONT,
    parameter int   V_PULSE  = VGA640_V_PULSE,
    parameter int   V_BACK   = VGA640_V_BACK,
    parameter logic HS_POL   = VGA640_HS_POL,
    parameter logic VS_POL   = VGA640_VS_POL,
    parameter int   LAT      = 1,
    parameter int   CW       = 8,
    parameter int   XW       = 10,
    parameter int   YW       = 10
) (
    input  logic          clock,
    input  logic          rst,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y,
    output logic          fetch_valid,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          blank_n,
    output logic          sync_n,
    output logic          vga_clk
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_PULSE, H_BACK);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_PULSE, V_BACK);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FRONT);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FRONT);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FRONT + V_PULSE);

    logic [XW-1:0] r_h;
    logic [YW-1:0] r_v;
    logic          w_h_wrap;
    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic          w_line_start;
    vga_flags_t    w_flags;
    vga_flags_t    w_flags_d;

    logic [CW-1:0] r_red;
    logic [CW-1:0] r_green;
    logic [CW-1:0] r_blue;
    logic          r_blank_n;
    logic          r_hsync;
    logic          r_vsync;

    assign w_h_wrap = (r_h == H_LAST);

    // v advances only on the h wrap, so vsync can only change at h=0.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_active     = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign w_hs         = (r_h >= HS_BEG) && (r_h < HS_END);
    assign w_vs         = (r_v >= VS_BEG) && (r_v < VS_END);
    assign w_line_start = (r_h == '0);

    assign fetch_valid  = w_active;
    assign fetch_x      = w_active ? r_h : '0;
    assign fetch_y      = w_active ? r_v : '0;
    assign line_start   = w_line_start;
    assign frame_start  = w_line_start && (r_v == '0);
    assign vblank_start = w_line_start && (r_v == V_ACT_C);
    assign vblank       = (r_v >= V_ACT_C);

    assign w_flags = {w_active, w_hs, w_vs};

    vga_delay_line #(
        .WIDTH ($bits(vga_flags_t)),
        .DEPTH (LAT)
    ) u_dly (
        .i_clk  (clock),
        .i_rst  (rst),
        .i_data (w_flags),
        .o_data (w_flags_d)
    );

    // Single output register stage: every pin toggles from a flop only.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
            r_blank_n <= 1'b0;
            r_hsync   <= ~HS_POL;
            r_vsync   <= ~VS_POL;
        end else begin
            r_red     <= w_flags_d.active ? r_in : '0;
            r_green   <= w_flags_d.active ? g_in : '0;
            r_blue    <= w_flags_d.active ? b_in : '0;
            r_blank_n <= w_flags_d.active;
            r_hsync   <= w_flags_d.hs ? HS_POL : ~HS_POL;
            r_vsync   <= w_flags_d.vs ? VS_POL : ~VS_POL;
        end
    end

    assign red     = r_red;
    assign green   = r_green;
    assign blue    = r_blue;
    assign blank_n = r_blank_n;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign sync_n  = 1'b0;
    assign vga_clk = clock;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Four vga_timing_gen instances (640x480 LAT=3, two small modes, 800x600) run in lockstep
// against a cycle-count based raster model, with random colour and random resets.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct {
        int ha, hf, hp, hb;
        int va, vf, vp, vb;
        int lat;
        int hpol, vpol;
    } geom_t;

    localparam int NCYC = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [4];
    logic [7:0]  ri [4], gi [4], bi [4];
    logic [10:0] fx [4];
    logic [9:0]  fy [4];
    logic        fv [4], ls [4], fs [4], vbs [4], vb [4];
    logic        hs [4], vs [4], bn [4], sn [4], vck [4];
    logic [7:0]  ro [4], go [4], bo [4];

    geom_t       g [4];
    string       nm [4];
    int          cyc [4];
    logic [23:0] cur_in [4];
    logic [23:0] prev_in [4];

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen #(.LAT(3), .XW(11), .YW(10)) u_def (
        .clock(clk), .rst(rst[0]), .r_in(ri[0]), .g_in(gi[0]), .b_in(bi[0]),
        .fetch_x(fx[0]), .fetch_y(fy[0]), .fetch_valid(fv[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .vblank_start(vbs[0]), .vblank(vb[0]), .hsync(hs[0]), .vsync(vs[0]),
        .red(ro[0]), .green(go[0]), .blue(bo[0]), .blank_n(bn[0]), .sync_n(sn[0]), .vga_clk(vck[0]));

    vga_timing_gen #(.H_ACTIVE(20), .H_FRONT(3), .H_PULSE(4), .H_BACK(5),
                     .V_ACTIVE(12), .V_FRONT(2), .V_PULSE(2), .V_BACK(3),
                     .HS_POL(1'b0), .VS_POL(1'b0), .LAT(2), .XW(11), .YW(10)) u_a (
        .clock(clk), .rst(rst[1]), .r_in(ri[1]), .g_in(gi[1]), .b_in(bi[1]),
        .fetch_x(fx[1]), .fetch_y(fy[1]), .fetch_valid(fv[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .vblank_start(vbs[1]), .vblank(vb[1]), .hsync(hs[1]), .vsync(vs[1]),
        .red(ro[1]), .green(go[1]), .blue(bo[1]), .blank_n(bn[1]), .sync_n(sn[1]), .vga_clk(vck[1]));

    vga_timing_gen #(.H_ACTIVE(16), .H_FRONT(2), .H_PULSE(5), .H_BACK(3),
                     .V_ACTIVE(8), .V_FRONT(1), .V_PULSE(3), .V_BACK(2),
                     .HS_POL(1'b1), .VS_POL(1'b1), .LAT(0), .XW(11), .YW(10)) u_b (
        .clock(clk), .rst(rst[2]), .r_in(ri[2]), .g_in(gi[2]), .b_in(bi[2]),
        .fetch_x(fx[2]), .fetch_y(fy[2]), .fetch_valid(fv[2]), .line_start(ls[2]),
        .frame_start(fs[2]), .vblank_start(vbs[2]), .vblank(vb[2]), .hsync(hs[2]), .vsync(vs[2]),
        .red(ro[2]), .green(go[2]), .blue(bo[2]), .blank_n(bn[2]), .sync_n(sn[2]), .vga_clk(vck[2]));

    vga_timing_gen #(.H_ACTIVE(SVGA800_H_ACTIVE), .H_FRONT(SVGA800_H_FRONT),
                     .H_PULSE(SVGA800_H_PULSE), .H_BACK(SVGA800_H_BACK),
                     .V_ACTIVE(SVGA800_V_ACTIVE), .V_FRONT(SVGA800_V_FRONT),
                     .V_PULSE(SVGA800_V_PULSE), .V_BACK(SVGA800_V_BACK),
                     .HS_POL(SVGA800_HS_POL), .VS_POL(SVGA800_VS_POL),
                     .LAT(1), .XW(11), .YW(10)) u_svga (
        .clock(clk), .rst(rst[3]), .r_in(ri[3]), .g_in(gi[3]), .b_in(bi[3]),
        .fetch_x(fx[3]), .fetch_y(fy[3]), .fetch_valid(fv[3]), .line_start(ls[3]),
        .frame_start(fs[3]), .vblank_start(vbs[3]), .vblank(vb[3]), .hsync(hs[3]), .vsync(vs[3]),
        .red(ro[3]), .green(go[3]), .blue(bo[3]), .blank_n(bn[3]), .sync_n(sn[3]), .vga_clk(vck[3]));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected raster state derived purely from cycles since the last reset edge.
    task automatic check_dut(input int id);
        geom_t q;
        int ht, vt, c, h, v, k, hk, vk, e_rgb;
        bit e_fv, act, hsa, vsa;
        q  = g[id];
        c  = cyc[id];
        ht = q.ha + q.hf + q.hp + q.hb;
        vt = q.va + q.vf + q.vp + q.vb;
        h  = c % ht;
        v  = (c / ht) % vt;
        e_fv = (h < q.ha) && (v < q.va);
        chk({nm[id], ".fetch_valid"},  fv[id],  e_fv);
        chk({nm[id], ".fetch_x"},      fx[id],  e_fv ? h : 0);
        chk({nm[id], ".fetch_y"},      fy[id],  e_fv ? v : 0);
        chk({nm[id], ".line_start"},   ls[id],  h == 0);
        chk({nm[id], ".frame_start"},  fs[id],  (h == 0) && (v == 0));
        chk({nm[id], ".vblank_start"}, vbs[id], (h == 0) && (v == q.va));
        chk({nm[id], ".vblank"},       vb[id],  v >= q.va);
        k = c - 1 - q.lat;
        if (k < 0) begin
            act = 0; hsa = 0; vsa = 0;
        end else begin
            hk  = k % ht;
            vk  = (k / ht) % vt;
            act = (hk < q.ha) && (vk < q.va);
            hsa = (hk >= q.ha + q.hf) && (hk < q.ha + q.hf + q.hp);
            vsa = (vk >= q.va + q.vf) && (vk < q.va + q.vf + q.vp);
        end
        e_rgb = act ? int'(prev_in[id]) : 0;
        chk({nm[id], ".blank_n"}, bn[id], act);
        chk({nm[id], ".hsync"},   hs[id], hsa ? q.hpol : 1 - q.hpol);
        chk({nm[id], ".vsync"},   vs[id], vsa ? q.vpol : 1 - q.vpol);
        chk({nm[id], ".rgb"},     int'({ro[id], go[id], bo[id]}), e_rgb);
        chk({nm[id], ".sync_n"},  sn[id], 0);
        chk({nm[id], ".vga_clk"}, vck[id], clk);
    endtask

    initial begin
        int  last_ls0, hs_run0, prev_red0, last_ls3, hs_run3, mid_stage;
        bit  prev_hs0, prev_bn0, prev_hs3;
        int  x;

        g[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 3, 0, 0};
        g[1] = '{20, 3, 4, 5, 12, 2, 2, 3, 2, 0, 0};
        g[2] = '{16, 2, 5, 3, 8, 1, 3, 2, 0, 1, 1};
        g[3] = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 1};
        nm[0] = "def"; nm[1] = "a"; nm[2] = "b"; nm[3] = "svga";
        last_ls0 = -1; hs_run0 = 0; prev_red0 = 0; prev_hs0 = 1; prev_bn0 = 0;
        last_ls3 = -1; hs_run3 = 0; prev_hs3 = 0; mid_stage = 0;

        for (int id = 0; id < 4; id++) begin
            rst[id]    = 1'b1;
            cyc[id]    = 0;
            cur_in[id] = 24'($urandom());
            prev_in[id] = '0;
            {ri[id], gi[id], bi[id]} = cur_in[id];
        end

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            for (int id = 0; id < 4; id++) begin
                cyc[id]     = rst[id] ? 0 : cyc[id] + 1;
                prev_in[id] = cur_in[id];
            end
            #1;
            for (int id = 0; id < 4; id++) begin
                cur_in[id] = 24'($urandom());
                if (n < 4) rst[id] = 1'b1;
                else       rst[id] = 1'b0;
            end
            if (n >= 4) begin
                if (mid_stage == 0 && cyc[1] == 6 * 32 + 10) begin
                    rst[1] = 1'b1;
                    mid_stage = 1;
                end else if (mid_stage >= 2) begin
                    rst[1] = ($urandom_range(0, 799) == 0);
                end
                rst[2] = ($urandom_range(0, 499) == 0);
            end
            // Colour source for the 640 mode: red carries the x of the coordinate issued LAT clocks ago.
            x = cyc[0] - 3;
            cur_in[0][23:16] = (x < 0) ? 8'd0 : 8'(x % 800);
            for (int id = 0; id < 4; id++) {ri[id], gi[id], bi[id]} = cur_in[id];

            @(negedge clk);
            for (int id = 0; id < 4; id++) check_dut(id);

            if (n == 4) begin
                chk("def.release_frame_start", fs[0], 1);
                chk("def.release_fetch_x", fx[0], 0);
                chk("def.release_fetch_y", fy[0], 0);
                chk("def.release_blank_n", bn[0], 0);
            end
            if (mid_stage == 1) begin
                chk("a.pre_rst_x", fx[1], 10);
                chk("a.pre_rst_y", fy[1], 6);
                mid_stage = 2;
            end else if (mid_stage == 2) begin
                chk("a.post_rst_frame_start", fs[1], 1);
                chk("a.post_rst_x", fx[1], 0);
                chk("a.post_rst_y", fy[1], 0);
                chk("a.post_rst_hsync", hs[1], 1);
                mid_stage = 3;
            end

            if (n >= 4) begin
                if (ls[0]) begin
                    if (last_ls0 >= 0) chk("def.line_period", cyc[0] - last_ls0, 800);
                    last_ls0 = cyc[0];
                end
                if (prev_hs0 && !hs[0]) chk("def.hs_fall_offset", cyc[0] - last_ls0, 656 + 3 + 1);
                if (!hs[0]) hs_run0++;
                else if (!prev_hs0) begin
                    chk("def.hs_low_len", hs_run0, 96);
                    hs_run0 = 0;
                end
                if (bn[0] && !prev_bn0) chk("def.red_first", ro[0], 0);
                if (!bn[0] && prev_bn0) chk("def.red_last", prev_red0, 127);
                prev_hs0 = hs[0]; prev_bn0 = bn[0]; prev_red0 = ro[0];

                if (ls[3]) begin
                    if (last_ls3 >= 0) chk("svga.line_period", cyc[3] - last_ls3, 1056);
                    last_ls3 = cyc[3];
                end
                if (hs[3]) hs_run3++;
                else if (prev_hs3) begin
                    chk("svga.hs_high_len", hs_run3, 128);
                    hs_run3 = 0;
                end
                prev_hs3 = hs[3];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
